uart_cmd_initiator: RTL
=======================

// Module: uart_cmd_initiator
// PURPOSE
//  Host side of the badge UART command protocol: builds and sends command frames
//  (shooting-flags, send-tx, AES key store, AES plaintext store) to a peer badge's command responder.
//  - Drives a byte-wide UART TX core (valid/ready) on the interconnect.
//  - Optionally captures the peer's 18-byte reply.
//  - Sits between the badge UI/challenge logic and the uart_top byte interface.
// PARAMETERS
//  CLK_FREQ        103_340_000  system clock in Hz
//  FRAME_BYTES     18           full frame length in bytes
//  RESP_TIMEOUT_MS 50           reply timeout, restarted by every received byte
// PORTS
//  clk          in   1    system clock
//  nreset       in   1    synchronous active-low reset
//  cmd_valid    in   1    command request
//  cmd_ready    out  1    high only in IDLE; transfer when cmd_valid&&cmd_ready
//  cmd_op       in   2    0=SHOOT 1=SEND_TX 2=KEY 3=PT
//  cmd_arg      in   8    argument byte (SHOOT, SEND_TX)
//  cmd_payload  in   128  payload (KEY, PT)
//  tx_data      out  8    byte to UART TX core
//  tx_valid     out  1    tx_data valid; held until tx_ready
//  tx_ready     in   1    TX core accepts byte
//  rx_data      in   8    byte from UART RX core
//  rx_valid     in   1    one-cycle strobe per received byte
//  resp_data    out  144  captured reply, first byte in [143:136]
//  resp_valid   out  1    one-cycle pulse, reply complete
//  resp_timeout out  1    one-cycle pulse, reply timed out
//  busy         out  1    not IDLE
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FSM=IDLE; counters=0; resp_data=0.
//  Mode bytes: SHOOT=65, SEND_TX=64, KEY=66, PT=67. Wire order is frame byte N-1 first, byte 0 last.
//  Frame sequences, by op:
//  - SHOOT (3 bytes):    mode, cmd_arg, mode.
//  - SEND_TX (18 bytes): mode, 15x 0x00, cmd_arg, mode.
//  - KEY/PT (18 bytes):  mode, payload[127:120] .. payload[7:0], mode.
//  Accept latches cmd_op, cmd_arg and cmd_payload; inputs may change afterwards.
//  FSM states:
//  - IDLE -> SEND on accept.
//  - SEND: tx_valid asserted the cycle after accept. Byte index advances only on tx_valid&&tx_ready.
//    tx_data and tx_valid are stable while tx_ready=0. Back-to-back bytes are allowed (one per cycle max).
//  - SEND -> after last byte handshake: WAIT_RESP if op==SEND_TX and RESP_EN, else IDLE.
//  - WAIT_RESP: each rx_valid shifts rx_data in at [7:0] of the shift register.
//    After 18 bytes, resp_data updates and resp_valid pulses 1 cycle -> IDLE.
//    Timeout counter = CLK_FREQ/1000*RESP_TIMEOUT_MS cycles, cleared on each rx_valid.
//    On expiry: resp_timeout pulses, resp_data unchanged -> IDLE.
//  - rx_valid outside WAIT_RESP is ignored.
//  - rx_valid in the same cycle as the last TX handshake is ignored; capture starts the next cycle.
//  nreset low mid-frame aborts at once: tx_valid=0 next cycle, no partial completion.
//  Byte counter is 5 bits, with no wrap beyond FRAME_BYTES-1.
// CONFIGURATION
//  UART_CMD_RESP_EN defined: WAIT_RESP state and capture logic present.
//  Undefined:
//  - SEND_TX returns to IDLE after its last byte.
//  - resp_data is tied 0; resp_valid and resp_timeout are tied 0.
//  - rx_data and rx_valid are unused.
// STRUCTURE
//  Package uart_cmd_pkg:
//  - mode byte constants (65/64/66/67)
//  - cmd_op encodings
//  - FSM state encoding
//  - FRAME_BYTES
//  - SHOOT_BYTES=3
//  Sub-module uart_cmd_resp_capture: shift register, byte count, timeout. Instantiated only under UART_CMD_RESP_EN.
// TESTING
//  1. SHOOT, arg 0x43, tx_ready tied 1 -> tx bytes 0x41,0x43,0x41 on consecutive cycles.
//     busy then drops; cmd_ready=1.
//  2. KEY, payload 0x00112233..EEFF, tx_ready toggled -> 18 bytes:
//     0x42, 0x00, 0x11 .. 0xFF, 0x42. tx_data stable whenever tx_ready=0.
//  3. SEND_TX, arg 0x41, then peer replies "{hi_i'm_your_army}" (RESP_EN)
//     -> resp_data[143:136]=0x7B, [7:0]=0x7D; resp_valid pulses once.
//  4. SEND_TX with only 5 reply bytes -> resp_timeout pulses once after the timeout.
//     resp_data unchanged; IDLE.
//  5. nreset low at byte 7 of a PT frame -> tx_valid=0 next cycle, cmd_ready=1.
//     A new SHOOT is sent correctly afterwards.
//  6. cmd_valid held high while busy -> no second accept until IDLE.
//     Without RESP_EN: SEND_TX returns to IDLE after its final 0x40.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
//------------------------------------------------------------------------------
// uart_cmd_pkg: frame constants, op/state encodings and frame byte helper
//               for the badge UART command initiator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_cmd_pkg;

  localparam int unsigned FRAME_BYTES = 18;
  localparam int unsigned SHOOT_BYTES = 3;

  localparam logic [7:0] MODE_SHOOT   = 8'd65;
  localparam logic [7:0] MODE_SEND_TX = 8'd64;
  localparam logic [7:0] MODE_KEY     = 8'd66;
  localparam logic [7:0] MODE_PT      = 8'd67;

  typedef enum logic [1:0] {
    OP_SHOOT   = 2'd0,
    OP_SEND_TX = 2'd1,
    OP_KEY     = 2'd2,
    OP_PT      = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RESP = 2'd2
  } state_e;

  function automatic logic [7:0] mode_byte(input cmd_op_e op);
    logic [7:0] m;
    case (op)
      OP_SHOOT:   m = MODE_SHOOT;
      OP_SEND_TX: m = MODE_SEND_TX;
      OP_KEY:     m = MODE_KEY;
      default:    m = MODE_PT;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] last_idx(input cmd_op_e op);
    return (op == OP_SHOOT) ? 5'(SHOOT_BYTES - 1) : 5'(FRAME_BYTES - 1);
  endfunction

  // idx is the send position: 0 goes out first, last_idx(op) last.
  function automatic logic [7:0] frame_byte(input cmd_op_e      op,
                                            input logic [7:0]   arg,
                                            input logic [127:0] payload,
                                            input logic [4:0]   idx);
    logic [127:0] sh;
    logic [7:0]   b;
    sh = payload >> (32'd8 * (32'd16 - 32'(idx)));
    b  = 8'h00;
    if (idx == 5'd0 || idx == last_idx(op)) begin
      b = mode_byte(op);
    end else begin
      case (op)
        OP_SHOOT:   b = arg;
        OP_SEND_TX: b = (idx == 5'd16) ? arg : 8'h00;
        default:    b = sh[7:0];
      endcase
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_resp_capture.sv
//------------------------------------------------------------------------------
// uart_cmd_resp_capture: collects the peer's 18-byte reply with a per-byte
//                        restarting timeout while en_i is high.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_resp_capture
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_167_000
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  input  logic         en_i,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic         finish_o,
  output logic [143:0] resp_data_o,
  output logic         resp_valid_o,
  output logic         resp_timeout_o
);

  localparam int unsigned RESP_W  = FRAME_BYTES * 8;
  localparam int unsigned SHIFT_W = RESP_W - 8;
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [RESP_W-1:0]  resp_q, resp_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               valid_q, valid_d;
  logic               tmo_q, tmo_d;
  logic               w_done;
  logic               w_expire;

  always_comb begin
    w_done   = en_i && rx_valid_i && (cnt_q == 5'(FRAME_BYTES - 1));
    w_expire = en_i && !rx_valid_i && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
    shift_d  = shift_q;
    resp_d   = resp_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    valid_d  = w_done;
    tmo_d    = w_expire;
    if (!en_i) begin
      cnt_d = 5'd0;
      to_d  = '0;
    end else if (rx_valid_i) begin
      // The final byte goes straight into the reply; the shifter only holds 17.
      shift_d = {shift_q[SHIFT_W-9:0], rx_data_i};
      to_d    = '0;
      if (w_done) begin
        resp_d = {shift_q, rx_data_i};
        cnt_d  = 5'd0;
      end else begin
        cnt_d = cnt_q + 5'd1;
      end
    end else if (w_expire) begin
      to_d = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      shift_q <= '0;
      resp_q  <= '0;
      cnt_q   <= 5'd0;
      to_q    <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  assign finish_o       = w_done || w_expire;
  assign resp_data_o    = resp_q;
  assign resp_valid_o   = valid_q;
  assign resp_timeout_o = tmo_q;

endmodule

`default_nettype wire

// File: rtl/uart_cmd_initiator.sv
//------------------------------------------------------------------------------
// uart_cmd_initiator: builds and sends badge command frames over a byte UART;
//                     UART_CMD_RESP_EN adds reply capture after SEND_TX.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_initiator
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 103_340_000,
  parameter int unsigned RESP_TIMEOUT_MS = 50
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [1:0]   cmd_op_i,
  input  logic [7:0]   cmd_arg_i,
  input  logic [127:0] cmd_payload_i,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic [143:0] resp_data_o,
  output logic         resp_valid_o,
  output logic         resp_timeout_o,
  output logic         busy_o
);

  localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1000 * RESP_TIMEOUT_MS;

  state_e         state_q, state_d;
  cmd_op_e        op_q;
  logic [7:0]     arg_q;
  logic [127:0]   payload_q;
  logic [4:0]     idx_q, idx_d;
  logic           w_load;
  logic           w_cap_finish;
  state_e         w_after_send;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_load  = 1'b1;
          idx_d   = 5'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready_i) begin
          if (idx_q == last_idx(op_q)) begin
            idx_d   = 5'd0;
            state_d = w_after_send;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_WAIT_RESP: begin
        if (w_cap_finish) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      op_q      <= OP_SHOOT;
      arg_q     <= 8'h00;
      payload_q <= '0;
    end else if (w_load) begin
      op_q      <= cmd_op_e'(cmd_op_i);
      arg_q     <= cmd_arg_i;
      payload_q <= cmd_payload_i;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign tx_valid_o  = (state_q == ST_SEND);
  assign tx_data_o   = tx_valid_o ? frame_byte(op_q, arg_q, payload_q, idx_q) : 8'h00;

`ifdef UART_CMD_RESP_EN
  assign w_after_send = (op_q == OP_SEND_TX) ? ST_WAIT_RESP : ST_IDLE;

  uart_cmd_resp_capture #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_capture (
    .clk_i          (clk_i),
    .nreset_i       (nreset_i),
    .en_i           (state_q == ST_WAIT_RESP),
    .rx_data_i      (rx_data_i),
    .rx_valid_i     (rx_valid_i),
    .finish_o       (w_cap_finish),
    .resp_data_o    (resp_data_o),
    .resp_valid_o   (resp_valid_o),
    .resp_timeout_o (resp_timeout_o)
  );
`else
  logic w_unused_rx;

  assign w_after_send   = ST_IDLE;
  assign w_cap_finish   = 1'b0;
  assign resp_data_o    = '0;
  assign resp_valid_o   = 1'b0;
  assign resp_timeout_o = 1'b0;
  assign w_unused_rx    = ^{rx_data_i, rx_valid_i, 32'(TIMEOUT_CYCLES)};
`endif

endmodule

`default_nettype wire
